// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - host-to-device PS/2 command byte transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err_noack,
  output logic       err_timeout
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_SHIFT,
    S_ACK,
    S_WAITIDLE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [2:0]    r_clk_sync;
  logic [2:0]    r_data_sync;
  logic          r_clk_prev;
  logic [8:0]    r_frame;
  logic [3:0]    r_bitcnt;
  logic          r_bit;
  logic          r_noack;
  logic [IW-1:0] r_inh_cnt;
  logic [TW-1:0] r_to_cnt;
  logic          r_done;
  logic          r_err_noack;
  logic          r_err_timeout;

  logic          w_clk_s;
  logic          w_data_s;
  logic          w_fall;
  logic          w_accept;
  logic          w_inh_last;
  logic          w_timing;
  logic          w_timeout;
  logic          w_bus_idle;

  assign w_clk_s    = r_clk_sync[2];
  assign w_data_s   = r_data_sync[2];
  assign w_fall     = r_clk_prev && !w_clk_s;
  assign w_accept   = tx_valid && (r_state == S_IDLE);
  assign w_inh_last = (r_inh_cnt == IW'(INHIBIT_CYCLES - 1));
  assign w_timing   = (r_state inside {S_RTS, S_SHIFT, S_ACK, S_WAITIDLE});
  assign w_timeout  = w_timing && (r_to_cnt >= TW'(TIMEOUT_CYCLES));
  assign w_bus_idle = w_clk_s && w_data_s;

  assign tx_ready    = (r_state == S_IDLE);
  assign busy        = ~tx_ready;
  assign done        = r_done;
  assign err_noack   = r_err_noack;
  assign err_timeout = r_err_timeout;

  // Bring the async bus lines into clk; reset to the idle-high level so no false fall appears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_sync  <= 3'b111;
      r_data_sync <= 3'b111;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[1:0], ps2_clk};
      r_data_sync <= {r_data_sync[1:0], ps2_data};
      r_clk_prev  <= r_clk_sync[2];
    end
  end

  // State register; async reset drops both pull-downs immediately via the output decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and line drive decode; a timeout overrides every other transition.
  always_comb begin
    w_next      = r_state;
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = S_INHIBIT;
      end
      S_INHIBIT: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = w_inh_last;
        if (w_inh_last) w_next = S_RTS;
      end
      S_RTS: begin
        ps2_data_oe = 1'b1;
        if (w_fall) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        ps2_data_oe = ~r_bit;
        if (w_fall && (r_bitcnt == 4'd9)) w_next = S_ACK;
      end
      S_ACK: begin
        if (w_fall) w_next = S_WAITIDLE;
      end
      S_WAITIDLE: begin
        if (w_bus_idle) w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    if (w_timeout) w_next = S_IDLE;
  end

  // Frame capture, bit sequencing on device clock falls, counters and result pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame       <= 9'd0;
      r_bitcnt      <= 4'd0;
      r_bit         <= 1'b1;
      r_noack       <= 1'b0;
      r_inh_cnt     <= '0;
      r_to_cnt      <= '0;
      r_done        <= 1'b0;
      r_err_noack   <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_accept) r_frame <= {~^tx_data, tx_data};

      if (r_state == S_INHIBIT) begin
        if (r_inh_cnt != {IW{1'b1}}) r_inh_cnt <= r_inh_cnt + IW'(1);
      end else begin
        r_inh_cnt <= '0;
      end

      if (w_timing) begin
        if (r_to_cnt != {TW{1'b1}}) r_to_cnt <= r_to_cnt + TW'(1);
      end else begin
        r_to_cnt <= '0;
      end

      case (r_state)
        S_INHIBIT: begin
          r_bitcnt <= 4'd0;
          r_noack  <= 1'b0;
          r_bit    <= 1'b1;
        end
        S_RTS: begin
          if (w_fall) begin
            r_bit    <= r_frame[0];
            r_bitcnt <= 4'd1;
          end
        end
        S_SHIFT: begin
          if (w_fall) begin
            if (r_bitcnt == 4'd9) r_bit <= 1'b1;
            else                  r_bit <= r_frame[r_bitcnt];
            r_bitcnt <= r_bitcnt + 4'd1;
          end
        end
        S_ACK: begin
          if (w_fall) r_noack <= w_data_s;
        end
        default: begin
        end
      endcase

      r_err_timeout <= w_timeout;
      r_done        <= (r_state == S_WAITIDLE) && w_bus_idle && !w_timeout && !r_noack;
      r_err_noack   <= (r_state == S_WAITIDLE) && w_bus_idle && !w_timeout && r_noack;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - randomized self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err_noack, err_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       line_clk, line_data;

  assign line_clk  = ~(ps2_clk_oe | dev_clk_low);
  assign line_data = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .ps2_clk(line_clk), .ps2_data(line_data),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
    .done(done), .err_noack(err_noack), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, n_done = 0, n_noack = 0, n_to = 0, n_multi = 0;
  int oe_run = 0, last_oe_run = 0, rts_cyc = 0, to_cyc = 0;
  logic prev_clk_oe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Observers: pulse counts, inhibit length, RTS entry and timeout cycle stamps.
  always @(negedge clk) begin
    cyc++;
    if (done) n_done++;
    if (err_noack) n_noack++;
    if (err_timeout) begin
      n_to++;
      to_cyc = cyc;
    end
    if (int'(done) + int'(err_noack) + int'(err_timeout) > 1) n_multi++;
    if (ps2_clk_oe) oe_run++;
    else if (prev_clk_oe) begin
      last_oe_run = oe_run;
      oe_run = 0;
      rts_cyc = cyc;
    end
    prev_clk_oe = ps2_clk_oe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // Reference: line pull-down expected in response to falls 1..10 for byte b.
  function automatic logic [9:0] exp_oe(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return ~{1'b1, par, b};
  endfunction

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device: wait for RTS, then clock nclk bits; mode 0 acks, 1 withholds ack, 2 never clocks.
  task automatic dev_frame(input int mode, input int nclk, output logic [9:0] oe_s,
                           output logic [9:0] bits_s, output logic ok);
    int k;
    oe_s = '0; bits_s = '0; ok = 1'b0; k = 0;
    while (line_clk && k < 200) begin @(negedge clk); k++; end
    while (!(line_clk && !line_data) && k < 400) begin @(negedge clk); k++; end
    if (k >= 400) return;
    ok = 1'b1;
    if (mode == 2) return;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= nclk; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      if (i <= 10) begin
        oe_s[i-1]   = ps2_data_oe;
        bits_s[i-1] = line_data;
      end
      dev_clk_low = 1'b0;
      repeat (HALF/2) @(negedge clk);
      if (i == 10) dev_data_low = (mode == 0);
      repeat (HALF/2) @(negedge clk);
      if (i == 11) dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_settle();
    int k;
    k = 0;
    while (!tx_ready && k < 200) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic [9:0] oe_s,
                             input logic [9:0] bits_s, input logic ok);
    check({tag, "_rts"}, ok, 1);
    check({tag, "_byte"}, bits_s[7:0], b);
    check({tag, "_parity"}, bits_s[8], (($countones(b) % 2) == 0));
    check({tag, "_stop"}, bits_s[9], 1);
    check({tag, "_oe_seq"}, oe_s, exp_oe(b));
  endtask

  task automatic do_frame(input logic [7:0] b, input int mode, input string tag);
    int d0, n0;
    logic [9:0] oe_s, bits_s;
    logic ok;
    d0 = n_done; n0 = n_noack;
    send(b);
    dev_frame(mode, 11, oe_s, bits_s, ok);
    wait_settle();
    check_frame(tag, b, oe_s, bits_s, ok);
    check({tag, "_done"}, n_done - d0, (mode == 0) ? 1 : 0);
    check({tag, "_noack"}, n_noack - n0, (mode == 1) ? 1 : 0);
    check({tag, "_ready"}, tx_ready, 1);
    check({tag, "_oe_idle"}, {ps2_clk_oe, ps2_data_oe}, 0);
  endtask

  initial begin
    int d0, n0, k;
    logic [9:0] oe_s, bits_s;
    logic ok;
    logic [7:0] rb;
    int rm;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_pulses", n_done + n_noack + n_to, 0);

    do_frame(8'hED, 0, "t1");
    check("t1_inhibit_len", last_oe_run, INH);

    d0 = n_done;
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge clk); tx_data = 8'hFF;
    dev_frame(0, 11, oe_s, bits_s, ok);
    check_frame("t2a", 8'h00, oe_s, bits_s, ok);
    k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    while (!busy && k < 400) begin @(negedge clk); k++; end
    check("t2_after_done", n_done - d0, 1);
    tx_valid = 1'b0;
    dev_frame(0, 11, oe_s, bits_s, ok);
    wait_settle();
    check_frame("t2b", 8'hFF, oe_s, bits_s, ok);
    check("t2_done2", n_done - d0, 2);

    do_frame(8'hF0, 1, "t3");

    n0 = n_to; d0 = n_done;
    send(8'h12);
    dev_frame(2, 11, oe_s, bits_s, ok);
    check("t4_rts", ok, 1);
    k = 0;
    while (n_to == n0 && k < TO + 200) begin @(negedge clk); k++; end
    @(negedge clk);
    check("t4_pulse", n_to - n0, 1);
    check("t4_latency", to_cyc - rts_cyc, TO + 1);
    check("t4_data_oe", ps2_data_oe, 0);
    check("t4_ready", tx_ready, 1);
    check("t4_no_done", n_done - d0, 0);

    d0 = n_done + n_noack + n_to;
    send(8'h55);
    dev_frame(0, 5, oe_s, bits_s, ok);
    check("t5_busy_mid", busy, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_oe_async", {ps2_clk_oe, ps2_data_oe}, 0);
    check("t5_ready_async", tx_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_no_pulse", n_done + n_noack + n_to - d0, 0);
    do_frame(8'h01, 0, "t5b");

    d0 = n_done;
    send(8'hF4);
    fork
      dev_frame(0, 11, oe_s, bits_s, ok);
      begin
        repeat (100) @(negedge clk);
        tx_valid = 1'b1; tx_data = 8'hAA;
        repeat (3) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    wait_settle();
    check_frame("t6", 8'hF4, oe_s, bits_s, ok);
    repeat (100) @(negedge clk);
    check("t6_not_queued", busy, 0);
    check("t6_done", n_done - d0, 1);

    for (int r = 0; r < 6; r++) begin
      rb = 8'($urandom);
      rm = $urandom_range(0, 1);
      do_frame(rb, rm, "rnd");
    end

    check("pulse_exclusive", n_multi, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
